// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the PISO serializer
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int MAX_WIDTH = 64;

    // Bits needed to count 0..width-1, never less than one.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    // Even parity bit of a word: XOR of all its bits.
    function automatic logic parity_of(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/piso_shift_reg_tx.sv
// rtl/piso_shift_reg_tx.sv - parallel-in serial-out serializer; optional parity bit via PISO_PARITY_EN
module piso_shift_reg_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_par,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic             dout_d, dout_valid_d, busy_d, done_d;
    logic             accept;
    logic             last_bit;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign accept   = load_valid && load_ready;

    // Ready is a pure function of state; the early assert overlaps the final frame bit.
    always_comb begin
        load_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    load_ready = 1'b1;
`ifdef PISO_PARITY_EN
                PARITY:  load_ready = 1'b1;
`else
                SHIFT:   load_ready = last_bit;
`endif
                default: load_ready = 1'b0;
            endcase
        end
    end

    // Next-state and next-output logic; a start loads the word and presents its first bit.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        sreg_d       = sreg;
        dout_d       = dout;
        dout_valid_d = dout_valid;
        busy_d       = busy;
        done_d       = 1'b0;
`ifdef PISO_PARITY_EN
        par_d        = par_q;
`endif

        case (state)
            SHIFT: begin
                if (cnt != LAST) begin
                    cnt_d  = cnt + CW'(1);
                    dout_d = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
                    sreg_d = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
                    dout_d  = par_q;
`else
                    done_d       = 1'b1;
                    state_d      = IDLE;
                    dout_d       = 1'b0;
                    dout_valid_d = 1'b0;
                    busy_d       = 1'b0;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                done_d       = 1'b1;
                state_d      = IDLE;
                dout_d       = 1'b0;
                dout_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
`endif
            default: state_d = IDLE;
        endcase

        // A start overrides the frame-end values so back-to-back frames have no gap.
        if (accept) begin
            state_d      = SHIFT;
            cnt_d        = '0;
            dout_d       = LSB_FIRST ? din_par[0] : din_par[WIDTH-1];
            sreg_d       = LSB_FIRST ? (din_par >> 1) : (din_par << 1);
            dout_valid_d = 1'b1;
            busy_d       = 1'b1;
`ifdef PISO_PARITY_EN
            par_d        = parity_of(MAX_WIDTH'(din_par));
`endif
        end
    end

    // State and registered outputs; reset aborts any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sreg       <= sreg_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef PISO_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_shift_reg_tx.sv
// tb/tb_piso_shift_reg_tx.sv - directed self-checking bench for piso_shift_reg_tx
module tb_piso_shift_reg_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din_par;
    logic       load_valid;
    logic       load_ready, dout, dout_valid, busy, done;
    logic       load_ready_m, dout_m, dout_valid_m, busy_m, done_m;
    logic [3:0] sipo_q;

    int n_checks = 0;
    int n_fail   = 0;

    piso_shift_reg_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din_par(din_par), .load_valid(load_valid),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .done(done)
    );

    piso_shift_reg_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .din_par(din_par), .load_valid(load_valid),
        .load_ready(load_ready_m), .dout(dout_m), .dout_valid(dout_valid_m),
        .busy(busy_m), .done(done_m)
    );

    always #5 clk = ~clk;

    // Reference 4-bit SIPO: new bit enters at the top so an LSB-first frame lands in order.
    always @(posedge clk) sipo_q <= {dout, sipo_q[3:1]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq;
        rst = 1'b1; din_par = 4'h0; load_valid = 1'b0;
        tick(); tick();
        check("rst_dout", dout, 0);
        check("rst_dv", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", load_ready, 0);
        rst = 1'b0; #1;
        check("idle_ready", load_ready, 1);

`ifdef PISO_PARITY_EN
        din_par = 4'b1011; load_valid = 1'b1; tick(); load_valid = 1'b0;
        seq = 8'b0001_1011;
        for (int i = 0; i < 5; i++) begin
            check("par_dout", dout, seq[i]);
            check("par_dv", dout_valid, 1);
            check("par_done", done, 0);
            check("par_ready", load_ready, (i == 4) ? 1 : 0);
            tick();
        end
        check("par_end_dv", dout_valid, 0);
        check("par_end_done", done, 1);
        tick();
        check("par_done_clear", done, 0);
`else
        // Single frame 1011, LSB first
        din_par = 4'b1011; load_valid = 1'b1; tick(); load_valid = 1'b0;
        seq = 8'b0000_1011;
        for (int i = 0; i < 4; i++) begin
            check("t1_dout", dout, seq[i]);
            check("t1_dv", dout_valid, 1);
            check("t1_busy", busy, 1);
            check("t1_done", done, 0);
            check("t1_ready", load_ready, (i == 3) ? 1 : 0);
            tick();
        end
        check("t1_end_dv", dout_valid, 0);
        check("t1_end_busy", busy, 0);
        check("t1_end_done", done, 1);
        check("t1_sipo", sipo_q, 4'b1011);
        tick();
        check("t1_done_clear", done, 0);

        // Back-to-back A then 5; din changes right after the first accept
        din_par = 4'hA; load_valid = 1'b1; tick(); din_par = 4'h5;
        seq = 8'b0101_1010;
        for (int i = 0; i < 8; i++) begin
            check("t2_dout", dout, seq[i]);
            check("t2_dv", dout_valid, 1);
            check("t2_busy", busy, 1);
            check("t2_done", done, (i == 4) ? 1 : 0);
            if (i == 4) check("t2_sipo_a", sipo_q, 4'hA);
            tick();
            if (i == 3) load_valid = 1'b0;
        end
        check("t2_end_dv", dout_valid, 0);
        check("t2_end_done", done, 1);
        check("t2_sipo_5", sipo_q, 4'h5);
        tick();
        check("t2_done_clear", done, 0);

        // Load pulse during bit 1 of an all-zero frame is dropped
        din_par = 4'h0; load_valid = 1'b1; tick(); load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_dout", dout, 0);
            check("t3_dv", dout_valid, 1);
            if (i == 1) begin
                din_par = 4'hF; load_valid = 1'b1; #1;
                check("t3_ready_low", load_ready, 0);
            end
            tick();
            load_valid = 1'b0;
        end
        check("t3_end_done", done, 1);
        check("t3_end_busy", busy, 0);
        tick();
        check("t3_idle_dv", dout_valid, 0);
        check("t3_idle_busy", busy, 0);
        check("t3_idle_dout", dout, 0);

        // Reset during bit 2 of 0110, then a fresh frame 9
        din_par = 4'b0110; load_valid = 1'b1; tick(); load_valid = 1'b0;
        tick(); tick();
        check("t4_bit2", dout, 1);
        rst = 1'b1; #1;
        check("t4_ready_in_rst", load_ready, 0);
        tick();
        check("t4_rst_dv", dout_valid, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_done", done, 0);
        rst = 1'b0; #1;
        check("t4_ready_after", load_ready, 1);
        tick();
        check("t4_no_done", done, 0);
        din_par = 4'h9; load_valid = 1'b1; tick(); load_valid = 1'b0;
        seq = 8'b0000_1001;
        for (int i = 0; i < 4; i++) begin
            check("t4_dout", dout, seq[i]);
            check("t4_dv", dout_valid, 1);
            tick();
        end
        check("t4_end_done", done, 1);
        check("t4_sipo", sipo_q, 4'h9);
        tick();

        // MSB-first instance on 1011
        din_par = 4'b1011; load_valid = 1'b1; tick(); load_valid = 1'b0;
        seq = 8'b0000_1101;
        for (int i = 0; i < 4; i++) begin
            check("t5_msb_dout", dout_m, seq[i]);
            check("t5_msb_dv", dout_valid_m, 1);
            tick();
        end
        check("t5_msb_done", done_m, 1);
        check("t5_msb_dv_end", dout_valid_m, 0);
        tick();
        check("t5_msb_done_clear", done_m, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
